scratchpad_mem_banked: RTL
==========================

Name: scratchpad_mem_banked

Overview:
- Parametrised successor to the fixed 4x8-bit scratchpad memory: NUM_BANKS byte-lane banks, configurable depth, and a registered read port.
- Adds an in-system loader that fills memory at run time, replacing simulation-only hex preload. Two loader modes: stream words over a valid/ready handshake, or clear a region to a constant.
- Sits between the core's load/store unit and the boot/debug path.

Parameters:
ADDR_WIDTH, 10, word-index bits; depth = 2^ADDR_WIDTH words
NUM_BANKS, 4, byte lanes per word (power of 2)
BANK_WIDTH, 8, bits per lane; word width W = NUM_BANKS*BANK_WIDTH

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
io_rdAddress  in  32  byte address of the read
io_rdData  out  W  registered read data
io_wrAddress  in  32  byte address of the write
io_wrData  in  W  write data
io_wrEnable  in  NUM_BANKS  per-lane write enable
io_ldStart  in  1  loader start pulse
io_ldMode  in  1  0 = STREAM, 1 = CLEAR
io_ldBase  in  ADDR_WIDTH  first word index to load
io_ldCount  in  ADDR_WIDTH+1  number of words (0..depth)
io_ldFill  in  W  constant used by CLEAR
io_ldValid  in  1  stream word valid
io_ldData  in  W  stream word
io_ldReady  out  1  loader accepts io_ldData
io_busy  out  1  loader active
io_done  out  1  one-cycle pulse when the load completes
io_wrDropped  out  1  pulse: a core write was discarded because the loader was busy

Behaviour:
- Word index = addr[log2(NUM_BANKS)+ADDR_WIDTH-1 : log2(NUM_BANKS)]. Upper address bits are ignored (aliasing); low lane bits are ignored.
- Reset (async assert, sync release): io_rdData=0, io_ldReady=0, io_busy=0, io_done=0, io_wrDropped=0, FSM=IDLE, counters=0. Memory contents are not reset.
- Read latency is 1 cycle: io_rdData in cycle N+1 reflects io_rdAddress in cycle N. Reads are always served, including while busy.
- Read-during-write to the same word: the result is write-first per lane. Enabled lanes return the new data; other lanes return the old data. The same rule applies to loader writes.
- Core write, when not busy: each lane i with io_wrEnable[i]=1 is written at the clock edge.
- Core write while busy: the write is discarded. io_wrDropped pulses the next cycle if any enable bit was set.
- FSM states: IDLE, STREAM, CLEAR, DONE.
  - IDLE: io_ldStart=1 latches base, count and fill, then moves to STREAM or CLEAR per io_ldMode. If count=0, it moves directly to DONE.
  - STREAM: io_ldReady=1. Each cycle with io_ldValid&&io_ldReady writes io_ldData (all lanes) at ptr, then ptr++ and remaining--. When remaining reaches 0, move to DONE. io_ldReady drops in the same edge.
  - CLEAR: writes fill at ptr every cycle, with ptr++ and remaining--, until remaining=0, then DONE. io_ldReady=0 throughout.
  - DONE: io_done=1 for exactly one cycle, then IDLE.
- io_busy=1 in STREAM, CLEAR and DONE; it is registered from the state.
- ptr wraps modulo depth (base=depth-1, count=2 writes depth-1 then 0). count=depth fills the whole memory.
- io_ldStart while not IDLE is ignored.
- io_ldValid stalls in STREAM wait indefinitely. No timeout.
- Reset asserted mid-load aborts immediately to IDLE. Partially written words stay written. No io_done pulse.

Decomposition:
- Shared package scratchpad_pkg holds:
  - the loader state enum (IDLE/STREAM/CLEAR/DONE);
  - LD_MODE_STREAM/LD_MODE_CLEAR constants;
  - a function returning the word index from a byte address.
- One sub-module, scratchpad_bank: single BANK_WIDTH x depth array with one write port, registered write-first read. It is generated NUM_BANKS times.
- The FSM, write-port mux (loader over core) and drop detection live in the top.

Test Plan:
- Reset, write word 0xDEADBEEF at byte address 0x10 with io_wrEnable=4'b1111, read 0x10 -> io_rdData=0xDEADBEEF one cycle after the address.
- Partial write: io_wrEnable=4'b0010, io_wrData=0x0000AA00 at 0x10 -> read returns 0xDEADAABE... specifically 0xDEADAAEF. Simultaneous read and write at 0x10 returns 0xDEADAAEF in the same following cycle.
- STREAM: base=5, count=3, send 0x11,0x22,0x33 with io_ldValid gaps -> words 5..7 hold 0x11/0x22/0x33. io_ldReady is low after the 3rd beat. io_done pulses once. io_busy spans start+1 through done.
- CLEAR wrap: ADDR_WIDTH=4, base=15, count=2, fill=0xFFFFFFFF -> words 15 and 0 are 0xFFFFFFFF, word 1 is untouched.
- Core write during CLEAR -> memory is unchanged at that address and io_wrDropped pulses one cycle later. A io_ldStart during busy is ignored.
- Assert reset_n low mid-STREAM after 1 of 4 words -> all outputs are 0 immediately and no io_done pulse occurs. A subsequent count=0 start gives io_done the cycle after io_ldStart.

Source files
------------

// File: rtl/scratchpad_mem_banked_pkg.sv
// rtl/scratchpad_mem_banked_pkg.sv - shared types, loader modes and address helper
package scratchpad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_CLEAR  = 2'd2,
        ST_DONE   = 2'd3
    } ld_state_t;

    localparam logic LD_MODE_STREAM = 1'b0;
    localparam logic LD_MODE_CLEAR  = 1'b1;

    // Drops the byte-lane bits; the caller keeps only the low ADDR_WIDTH bits.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input int unsigned lane_bits);
        return byte_addr >> lane_bits;
    endfunction

endpackage

// File: rtl/scratchpad_mem_banked_if.sv
// rtl/scratchpad_mem_banked_if.sv - core access and loader bus of the banked scratchpad
interface scratchpad_mem_banked_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_WIDTH = 8
);
    localparam int W = NUM_BANKS * BANK_WIDTH;

    logic [31:0]           io_rdAddress;
    logic [W-1:0]          io_rdData;
    logic [31:0]           io_wrAddress;
    logic [W-1:0]          io_wrData;
    logic [NUM_BANKS-1:0]  io_wrEnable;
    logic                  io_ldStart;
    logic                  io_ldMode;
    logic [ADDR_WIDTH-1:0] io_ldBase;
    logic [ADDR_WIDTH:0]   io_ldCount;
    logic [W-1:0]          io_ldFill;
    logic                  io_ldValid;
    logic [W-1:0]          io_ldData;
    logic                  io_ldReady;
    logic                  io_busy;
    logic                  io_done;
    logic                  io_wrDropped;

    modport master (
        output io_rdAddress, io_wrAddress, io_wrData, io_wrEnable,
               io_ldStart, io_ldMode, io_ldBase, io_ldCount, io_ldFill,
               io_ldValid, io_ldData,
        input  io_rdData, io_ldReady, io_busy, io_done, io_wrDropped
    );

    modport slave (
        input  io_rdAddress, io_wrAddress, io_wrData, io_wrEnable,
               io_ldStart, io_ldMode, io_ldBase, io_ldCount, io_ldFill,
               io_ldValid, io_ldData,
        output io_rdData, io_ldReady, io_busy, io_done, io_wrDropped
    );

endinterface

// File: rtl/scratchpad_mem_banked_bank.sv
// rtl/scratchpad_mem_banked_bank.sv - one byte lane: single write port, registered write-first read
module scratchpad_bank #(
    parameter int ADDR_WIDTH = 10,
    parameter int BANK_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [BANK_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [BANK_WIDTH-1:0] rd_data
);

    logic [BANK_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (we && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/scratchpad_mem_banked.sv
// rtl/scratchpad_mem_banked.sv - banked scratchpad with run-time stream/clear loader
module scratchpad_mem_banked #(
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    scratchpad_mem_banked_if.slave  bus
);
    import scratchpad_pkg::*;

    localparam int          W         = NUM_BANKS * BANK_WIDTH;
    localparam int unsigned LANE_BITS = $clog2(NUM_BANKS);

    ld_state_t             state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [W-1:0]          fill;
    logic                  ld_ready;
    logic                  busy;
    logic                  done;
    logic                  wr_dropped;

    logic [31:0]           rd_word_full;
    logic [31:0]           wr_word_full;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic                  stream_fire;
    logic                  ld_we;
    logic [W-1:0]          ld_word;
    logic                  unused_ok;

    assign rd_word_full = word_index(bus.io_rdAddress, LANE_BITS);
    assign wr_word_full = word_index(bus.io_wrAddress, LANE_BITS);
    assign rd_idx       = rd_word_full[ADDR_WIDTH-1:0];
    assign wr_idx       = wr_word_full[ADDR_WIDTH-1:0];
    assign unused_ok    = ^{rd_word_full[31:ADDR_WIDTH], wr_word_full[31:ADDR_WIDTH]};

    // The loader owns the write port whenever it writes; core writes only land while idle.
    assign stream_fire = (state == ST_STREAM) && bus.io_ldValid && ld_ready;
    assign ld_we       = stream_fire || (state == ST_CLEAR);
    assign ld_word     = (state == ST_CLEAR) ? fill : bus.io_ldData;

    assign bus.io_ldReady   = ld_ready;
    assign bus.io_busy      = busy;
    assign bus.io_done      = done;
    assign bus.io_wrDropped = wr_dropped;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            remaining  <= '0;
            fill       <= '0;
            ld_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_dropped <= 1'b0;
        end else begin
            wr_dropped <= busy && (|bus.io_wrEnable);
            done       <= 1'b0;
            if (ld_we) begin
                ptr       <= ptr + ADDR_WIDTH'(1);
                remaining <= remaining - (ADDR_WIDTH + 1)'(1);
            end
            unique case (state)
                ST_IDLE: begin
                    if (bus.io_ldStart) begin
                        ptr       <= bus.io_ldBase;
                        remaining <= bus.io_ldCount;
                        fill      <= bus.io_ldFill;
                        busy      <= 1'b1;
                        if (bus.io_ldCount == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else if (bus.io_ldMode == LD_MODE_CLEAR) begin
                            state <= ST_CLEAR;
                        end else begin
                            state    <= ST_STREAM;
                            ld_ready <= 1'b1;
                        end
                    end
                end
                ST_STREAM, ST_CLEAR: begin
                    if (ld_we && (remaining == (ADDR_WIDTH + 1)'(1))) begin
                        state    <= ST_DONE;
                        ld_ready <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        logic [BANK_WIDTH-1:0] lane_rd;

        scratchpad_bank #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .BANK_WIDTH (BANK_WIDTH)
        ) u_bank (
            .clock   (clock),
            .reset_n (reset_n),
            .we      (ld_we || (!busy && bus.io_wrEnable[i])),
            .wr_addr (ld_we ? ptr : wr_idx),
            .wr_data (ld_we ? ld_word[i*BANK_WIDTH +: BANK_WIDTH]
                            : bus.io_wrData[i*BANK_WIDTH +: BANK_WIDTH]),
            .rd_addr (rd_idx),
            .rd_data (lane_rd)
        );

        assign bus.io_rdData[i*BANK_WIDTH +: BANK_WIDTH] = lane_rd;
    end

endmodule
